// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller and the control unit:
// FSM state encodings and default handler vector layout.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_ISR      = 2'd2
    } int_state_t;

    localparam int DEF_N_IRQ      = 4;
    localparam int DEF_PC_W       = 10;
    localparam int DEF_VEC_BASE   = 'h3C0;
    localparam int DEF_VEC_STRIDE = 4;

endpackage

// File: rtl/int_ctrl_sync_edge.sv
// irq_sync_edge: two-flop synchroniser for one raw IRQ line followed by a
// rising-edge detector. The pulse is high for one cycle after the
// synchronised level rises; the consumer registers it into pend.
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic pulse
);

    logic s1, s2, s3;

    // metastability chain plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= irq;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: vectored interrupt controller. Synchronises and edge-detects
// the IRQ lines, latches them as pending, and dispatches the lowest-index
// unmasked pending line with a one-cycle take_int / irq_ack / vector.
// Optional feature macro: INT_NESTING_EN (allows strictly higher-priority
// preemption while in ISR).
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int N_IRQ      = DEF_N_IRQ,
    parameter int PC_W       = DEF_PC_W,
    parameter int VEC_BASE   = DEF_VEC_BASE,
    parameter int VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             int_en,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_d,
    input  logic             reti,
    output logic             take_int,
    output logic [PC_W-1:0]  vector,
    output logic [N_IRQ-1:0] irq_ack,
    output logic [N_IRQ-1:0] in_svc,
    output logic [N_IRQ-1:0] pend
);

    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    int_state_t       state;
    logic [ID_W-1:0]  id;
    logic [N_IRQ-1:0] edge_p;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] cand;
    logic             cand_any;
    logic [ID_W-1:0]  win_id;
    logic [N_IRQ-1:0] win_oh;
    logic [PC_W-1:0]  win_vec;
    logic [N_IRQ-1:0] pend_clr;
    logic [N_IRQ-1:0] svc_low;
    logic [N_IRQ-1:0] svc_next;
    logic             can_preempt;

    irq_sync_edge u_sync [N_IRQ-1:0] (
        .clk   (clk),
        .reset (reset),
        .irq   (irq),
        .pulse (edge_p)
    );

    assign cand     = pend & mask;
    assign cand_any = |cand;
    assign win_oh   = N_IRQ'(1) << win_id;
    assign win_vec  = PC_W'(VEC_BASE + int'(win_id) * VEC_STRIDE);
    // lowest set in_svc bit is the highest-priority level being serviced
    assign svc_low  = in_svc & (~in_svc + N_IRQ'(1));
    assign svc_next = in_svc & ~svc_low;
    assign pend_clr = (state == ST_DISPATCH) ? (N_IRQ'(1) << id) : '0;

    // priority encoder: lowest set index of cand wins
    always_comb begin
        win_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) win_id = ID_W'(i);
        end
    end

`ifdef INT_NESTING_EN
    logic [ID_W-1:0] svc_id;

    // index of the highest-priority level currently in service
    always_comb begin
        svc_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (in_svc[i]) svc_id = ID_W'(i);
        end
    end

    assign can_preempt = int_en & cand_any & (win_id < svc_id);
`else
    assign can_preempt = 1'b0;
`endif

    // mask register, all lines disabled out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mask <= '0;
        else if (mask_we) mask <= mask_d;
    end

    // pending latch: a new edge wins over the dispatch clear on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pend <= '0;
        else        pend <= (pend & ~pend_clr) | edge_p;
    end

    // dispatch FSM with registered one-cycle dispatch outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            id       <= '0;
            take_int <= 1'b0;
            irq_ack  <= '0;
            vector   <= '0;
            in_svc   <= '0;
        end else begin
            take_int <= 1'b0;
            irq_ack  <= '0;
            vector   <= '0;
            case (state)
                ST_IDLE: begin
                    if (int_en && cand_any && (in_svc == '0)) begin
                        state    <= ST_DISPATCH;
                        id       <= win_id;
                        take_int <= 1'b1;
                        irq_ack  <= win_oh;
                        vector   <= win_vec;
                    end
                end
                ST_DISPATCH: begin
                    state  <= ST_ISR;
                    in_svc <= in_svc | (N_IRQ'(1) << id);
                end
                ST_ISR: begin
                    if (reti) begin
                        in_svc <= svc_next;
                        state  <= (svc_next == '0) ? ST_IDLE : ST_ISR;
                    end else if (can_preempt) begin
                        state    <= ST_DISPATCH;
                        id       <= win_id;
                        take_int <= 1'b1;
                        irq_ack  <= win_oh;
                        vector   <= win_vec;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: table of single-shot dispatch vectors
// plus hand-written multi-cycle sequences (reset mid-ISR, back-to-back,
// global disable, preemption, set-over-clear).
module tb_int_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] irq;
    logic       int_en;
    logic       mask_we;
    logic [3:0] mask_d;
    logic       reti;
    logic       take_int;
    logic [9:0] vector;
    logic [3:0] irq_ack;
    logic [3:0] in_svc;
    logic [3:0] pend;

    int n_chk  = 0;
    int n_fail = 0;

    int_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .irq      (irq),
        .int_en   (int_en),
        .mask_we  (mask_we),
        .mask_d   (mask_d),
        .reti     (reti),
        .take_int (take_int),
        .vector   (vector),
        .irq_ack  (irq_ack),
        .in_svc   (in_svc),
        .pend     (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] irq;
        logic [3:0] mask;
        logic [3:0] ack;
        logic [9:0] vec;
    } vec_t;

    vec_t tv [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        irq     = '0;
        reti    = 1'b0;
        mask_we = 1'b0;
        mask_d  = '0;
        int_en  = 1'b0;
        reset   = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_d  = m;
        mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic pulse_reti();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    initial begin
        int bad;
        // irq, mask, expected ack, expected vector
        tv[0] = '{4'b0100, 4'b0100, 4'b0100, 10'h3C8};
        tv[1] = '{4'b1010, 4'b1111, 4'b0010, 10'h3C4};
        tv[2] = '{4'b0001, 4'b1111, 4'b0001, 10'h3C0};
        tv[3] = '{4'b1000, 4'b1000, 4'b1000, 10'h3CC};
        tv[4] = '{4'b0011, 4'b0010, 4'b0010, 10'h3C4};
        tv[5] = '{4'b0100, 4'b0000, 4'b0000, 10'h000};
        tv[6] = '{4'b1111, 4'b1100, 4'b0100, 10'h3C8};

        // reset state, before any clock edge
        reset = 1'b0; irq = '0; int_en = 1'b0; mask_we = 1'b0; mask_d = '0; reti = 1'b0;
        #1;
        chk("rst_take_int", take_int, 0);
        chk("rst_vector",   vector,   0);
        chk("rst_ack",      irq_ack,  0);
        chk("rst_in_svc",   in_svc,   0);
        chk("rst_pend",     pend,     0);

        // table: single dispatch with exact latency
        for (int v = 0; v < 7; v++) begin
            do_reset();
            set_mask(tv[v].mask);
            int_en = 1'b1;
            irq    = tv[v].irq;
            tick(); tick();
            chk($sformatf("t%0d_pend_E2", v), pend, 0);
            tick();
            chk($sformatf("t%0d_pend_E3", v), pend, tv[v].irq);
            chk($sformatf("t%0d_take_E3", v), take_int, 0);
            tick();
            chk($sformatf("t%0d_take_E4", v), take_int, (tv[v].ack != 0) ? 1 : 0);
            chk($sformatf("t%0d_ack", v),     irq_ack, tv[v].ack);
            chk($sformatf("t%0d_vector", v),  vector,  tv[v].vec);
            tick();
            chk($sformatf("t%0d_in_svc", v),  in_svc, tv[v].ack);
            chk($sformatf("t%0d_pend_E5", v), pend, tv[v].irq & ~tv[v].ack);
            chk($sformatf("t%0d_take_E5", v), take_int, 0);
            irq = '0;
            pulse_reti();
            chk($sformatf("t%0d_in_svc_ret", v), in_svc, 0);
        end

        // reset asserted mid-ISR acts asynchronously; mask returns to disabled
        do_reset();
        set_mask(4'b0100);
        int_en = 1'b1;
        irq    = 4'b0100;
        repeat (5) tick();
        chk("rmid_in_svc_before", in_svc, 4'b0100);
        irq = '0;
        #2 reset = 1'b0;
        #1;
        chk("rmid_in_svc", in_svc, 0);
        chk("rmid_pend",   pend,   0);
        chk("rmid_take",   take_int, 0);
        tick();
        reset = 1'b1;
        tick();
        irq = 4'b0100;
        bad = 0;
        repeat (6) begin
            tick();
            if (take_int !== 1'b0) bad++;
        end
        chk("rmid_mask_blocks", bad, 0);
        chk("rmid_pend_after",  pend, 4'b0100);

        // simultaneous lines 3 and 1: line 1 first, line 3 after reti + 1 idle cycle
        do_reset();
        set_mask(4'hF);
        int_en = 1'b1;
        irq    = 4'b1010;
        repeat (4) tick();
        chk("b2b_vec1", vector, 10'h3C4);
        tick();
        chk("b2b_svc1",  in_svc, 4'b0010);
        chk("b2b_pend3", pend,   4'b1000);
        tick(); tick();
        chk("b2b_wait", take_int, 0);
        pulse_reti();
        chk("b2b_idle_take", take_int, 0);
        chk("b2b_idle_svc",  in_svc,   0);
        tick();
        chk("b2b_take3", take_int, 1);
        chk("b2b_vec3",  vector,   10'h3CC);
        chk("b2b_ack3",  irq_ack,  4'b1000);
        tick();
        chk("b2b_svc3",  in_svc, 4'b1000);
        chk("b2b_pend0", pend,   0);

        // global disable holds pending; dispatch survives int_en drop and mask change
        do_reset();
        set_mask(4'hF);
        irq = 4'b0001;
        repeat (3) tick();
        chk("dis_pend", pend, 4'b0001);
        bad = 0;
        repeat (20) begin
            tick();
            if (take_int !== 1'b0) bad++;
        end
        chk("dis_no_take", bad, 0);
        int_en = 1'b1;
        tick();
        chk("dis_take", take_int, 1);
        chk("dis_vec",  vector,   10'h3C0);
        int_en  = 1'b0;
        mask_d  = 4'b0000;
        mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
        chk("dis_svc",  in_svc, 4'b0001);
        chk("dis_pend_clr", pend, 0);
        pulse_reti();
        chk("dis_ret", in_svc, 0);

        // higher-priority request while servicing line 2
        do_reset();
        set_mask(4'hF);
        int_en = 1'b1;
        irq    = 4'b0100;
        repeat (5) tick();
        chk("nest_svc2", in_svc, 4'b0100);
        irq = 4'b0101;
`ifdef INT_NESTING_EN
        repeat (4) tick();
        chk("nest_take", take_int, 1);
        chk("nest_vec",  vector,   10'h3C0);
        tick();
        chk("nest_svc", in_svc, 4'b0101);
        pulse_reti();
        chk("nest_ret1", in_svc, 4'b0100);
        pulse_reti();
        chk("nest_ret2", in_svc, 0);
`else
        bad = 0;
        repeat (10) begin
            tick();
            if (take_int !== 1'b0) bad++;
        end
        chk("nonest_no_take", bad, 0);
        chk("nonest_pend", pend, 4'b0001);
        pulse_reti();
        chk("nonest_ret", in_svc, 0);
        tick();
        chk("nonest_take", take_int, 1);
        chk("nonest_vec",  vector,   10'h3C0);
        tick();
        chk("nonest_svc0", in_svc, 4'b0001);
`endif

        // irq[1] re-edge lands on the clearing edge; reti in DISPATCH/IDLE ignored
        do_reset();
        set_mask(4'hF);
        int_en = 1'b1;
        irq    = 4'b0010;
        tick();
        irq = 4'b0000;
        tick();
        irq = 4'b0010;
        tick();
        chk("soc_pend_E3", pend, 4'b0010);
        tick();
        chk("soc_take", take_int, 1);
        chk("soc_vec",  vector,   10'h3C4);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("soc_pend_kept", pend,   4'b0010);
        chk("soc_svc",       in_svc, 4'b0010);
        int_en = 1'b0;
        pulse_reti();
        chk("soc_ret", in_svc, 0);
        pulse_reti();
        chk("soc_idle_reti_svc",  in_svc,   0);
        chk("soc_idle_reti_pend", pend,     4'b0010);
        chk("soc_idle_reti_take", take_int, 0);
        int_en = 1'b1;
        tick();
        chk("soc_redispatch", take_int, 1);
        chk("soc_revec",      vector,   10'h3C4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
